// File: rtl/port_packet_buffer.sv
// port_packet_buffer: per-output-port packet buffer behind the packet receiver.
// The receiver stages bytes into the current write slot and commits each packet
// with a winc pulse. Committed packets are replayed in arrival order as a
// valid/ready byte stream toward the output port.
//
// Ports:
//   clk1      clock; all state updates on the rising edge
//   rst       asynchronous active-low reset
//   wdata     byte to write into the current write slot
//   waddr     byte offset within the current write slot
//   wen       byte write strobe
//   winc      one-cycle commit pulse that closes the current packet
//   wfull     registered: every slot holds a committed packet
//   data_o    output byte
//   valid_o   data_o is valid
//   ready_i   consumer accepts data_o
//   last_o    data_o is the final byte of its packet
//   drop_cnt  commits rejected while full, saturating at 255
module port_packet_buffer #(
  parameter int unsigned PTR_IN_SZ = 4,
  parameter int unsigned UWIDTH    = 8,
  parameter int unsigned NSLOT     = 2
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic [UWIDTH-1:0]    wdata,
  input  logic [PTR_IN_SZ-1:0] waddr,
  input  logic                 wen,
  input  logic                 winc,
  output logic                 wfull,
  output logic [UWIDTH-1:0]    data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned DEPTH = 1 << PTR_IN_SZ;
  localparam int unsigned SW    = $clog2(NSLOT);
  localparam int unsigned LW    = PTR_IN_SZ + 1;
  localparam int unsigned CW    = $clog2(NSLOT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Packet storage and per-slot bookkeeping
  logic [UWIDTH-1:0]    mem [NSLOT][DEPTH];
  logic [LW-1:0]        len [NSLOT];
  logic [NSLOT-1:0]     full;
  logic [SW-1:0]        wsel;
  logic [SW-1:0]        rsel;
  logic [CW-1:0]        occ;
  logic [PTR_IN_SZ-1:0] rptr;
  state_t               state;

  logic                 rel_c;
  logic                 wr_ok_c;
  logic                 commit_c;
  logic                 drop_c;
  logic                 wr_c;
  logic [SW-1:0]        rsel_nxt_c;
  logic [PTR_IN_SZ-1:0] rptr_nxt_c;
  logic [LW-1:0]        last_idx_c;
  logic [CW-1:0]        occ_nxt_c;

  // Handshake/commit decode shared by the write side and the reader
  always_comb begin
    rel_c      = 1'b0;
    wr_ok_c    = 1'b0;
    commit_c   = 1'b0;
    drop_c     = 1'b0;
    wr_c       = 1'b0;
    rsel_nxt_c = rsel + SW'(1);
    rptr_nxt_c = rptr + PTR_IN_SZ'(1);
    last_idx_c = len[rsel] - LW'(1);
    occ_nxt_c  = occ;

    // Final-byte handshake frees slot rsel this cycle.
    rel_c = (state == SEND) && valid_o && ready_i && last_o;
    // A release in the same cycle frees the slot that a commit would land in
    // (wsel == rsel when every slot is full), so the commit is accepted.
    wr_ok_c  = !wfull || rel_c;
    commit_c = winc && wr_ok_c;
    drop_c   = winc && !wr_ok_c;
    wr_c     = wen && wr_ok_c;

    occ_nxt_c = occ + CW'(commit_c) - CW'(rel_c);
  end

  // Byte storage; contents are don't-care after reset
  always_ff @(posedge clk1) begin
    if (wr_c) begin
      mem[wsel][waddr] <= wdata;
    end
  end

  // Write side: slot occupancy, lengths, write pointer, wfull and drop counter
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      full     <= '0;
      wsel     <= '0;
      occ      <= '0;
      wfull    <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < int'(NSLOT); i++) begin
        len[i] <= '0;
      end
    end else begin
      // Release before commit so a same-slot commit wins.
      if (rel_c) begin
        full[rsel] <= 1'b0;
      end
      if (commit_c) begin
        full[wsel] <= 1'b1;
        len[wsel]  <= {1'b0, waddr} + LW'(1);
        wsel       <= wsel + SW'(1);
      end
      if (drop_c && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      occ   <= occ_nxt_c;
      wfull <= (occ_nxt_c == CW'(NSLOT));
    end
  end

  // Read FSM: fetch first byte, then stream with a one-byte prefetch
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rsel    <= '0;
      rptr    <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rsel]) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          rptr    <= '0;
          data_o  <= mem[rsel][0];
          last_o  <= (len[rsel] == LW'(1));
          valid_o <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (valid_o && ready_i) begin
            if (last_o) begin
              valid_o <= 1'b0;
              last_o  <= 1'b0;
              rsel    <= rsel_nxt_c;
              state   <= full[rsel_nxt_c] ? FETCH : IDLE;
            end else begin
              rptr   <= rptr_nxt_c;
              data_o <= mem[rsel][rptr_nxt_c];
              last_o <= ({1'b0, rptr_nxt_c} == last_idx_c);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_packet_buffer.sv
// Scoreboard bench for port_packet_buffer: committed packets push expected
// bytes; a negedge monitor pops and compares on every valid/ready handshake
// and checks that outputs hold while stalled.
module tb_port_packet_buffer;

  logic       clk1;
  logic       rst;
  logic [7:0] wdata;
  logic [3:0] waddr;
  logic       wen;
  logic       winc;
  logic       wfull;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       last_o;
  logic [7:0] drop_cnt;

  port_packet_buffer #(
    .PTR_IN_SZ(4),
    .UWIDTH   (8),
    .NSLOT    (2)
  ) dut (
    .clk1    (clk1),
    .rst     (rst),
    .wdata   (wdata),
    .waddr   (waddr),
    .wen     (wen),
    .winc    (winc),
    .wfull   (wfull),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o),
    .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pkt[$];
  int         tests = 0;
  int         fails = 0;

  logic       stalled = 1'b0;
  logic [7:0] hold_d  = '0;
  logic       hold_l  = 1'b0;

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted byte and verify stall stability
  always @(negedge clk1) begin
    exp_t e;
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        tests++;
        if (!valid_o || data_o !== hold_d || last_o !== hold_l) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   valid_o, data_o, last_o, hold_d, hold_l);
        end
      end
      if (valid_o && ready_i) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte: got d=%0h l=%0b expected none", data_o, last_o);
        end else begin
          e = sb.pop_front();
          if (data_o !== e.d || last_o !== e.l) begin
            fails++;
            $display("FAIL stream_byte: got d=%0h l=%0b expected d=%0h l=%0b",
                     data_o, last_o, e.d, e.l);
          end
        end
      end
      stalled = valid_o && !ready_i;
      hold_d  = data_o;
      hold_l  = last_o;
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Write pkt[0..n-1] at waddr 0..n-1 with winc on the last byte
  task automatic write_pkt(input int n, input bit ok);
    for (int i = 0; i < n; i++) begin
      wen   = 1'b1;
      waddr = 4'(i);
      wdata = pkt[i];
      winc  = (i == n - 1);
      if (i == n - 1 && ok) begin
        for (int j = 0; j < n; j++) begin
          sb.push_back({pkt[j], (j == n - 1)});
        end
      end
      tick();
    end
    wen  = 1'b0;
    winc = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || valid_o) && k < 200) begin
      tick();
      k++;
    end
    check(name, 32'((sb.size() == 0) && !valid_o), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!valid_o && k < 50) begin
      tick();
      k++;
    end
    check(name, 32'(valid_o), 32'd1);
  endtask

  initial begin
    int pat[6];
    int k;
    bit found;
    pat = '{1, 0, 0, 1, 0, 1};
    rst = 1'b0; wdata = '0; waddr = '0; wen = 1'b0; winc = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_last", 32'(last_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Basic 5-byte packet, latency of two edges after commit
    ready_i = 1'b1;
    pkt = '{8'h01, 8'h05, 8'h02, 8'hAA, 8'h55};
    write_pkt(5, 1'b1);
    check("lat_e0", 32'(valid_o), 32'd0);
    tick();
    check("lat_e1", 32'(valid_o), 32'd0);
    tick();
    check("lat_e2", 32'(valid_o), 32'd1);
    drain("drain_basic");

    // Two packets while stalled, third commit dropped
    ready_i = 1'b0;
    pkt = '{8'h10, 8'h11, 8'h12};
    write_pkt(3, 1'b1);
    check("wfull_one", 32'(wfull), 32'd0);
    pkt = '{8'h20, 8'h21};
    write_pkt(2, 1'b1);
    check("wfull_two", 32'(wfull), 32'd1);
    pkt = '{8'h30};
    write_pkt(1, 1'b0);
    check("drop_cnt_1", 32'(drop_cnt), 32'd1);
    check("wfull_drop", 32'(wfull), 32'd1);
    ready_i = 1'b1;
    k = 0;
    while (wfull && k < 30) begin
      tick();
      k++;
    end
    check("wfull_clear", 32'(wfull), 32'd0);
    check("wfull_clear_at_first_last", 32'(sb.size()), 32'd2);
    drain("drain_two");

    // Backpressure pattern during a 6-byte packet
    ready_i = 1'b0;
    pkt = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    write_pkt(6, 1'b1);
    wait_valid("bp_valid");
    k = 0;
    while ((sb.size() != 0 || valid_o) && k < 60) begin
      ready_i = pat[k % 6][0];
      tick();
      k++;
    end
    check("bp_done", 32'(sb.size()), 32'd0);
    ready_i = 1'b1;
    drain("drain_bp");

    // Commit while full in the same cycle as a final-byte handshake
    ready_i = 1'b0;
    pkt = '{8'h40, 8'h41};
    write_pkt(2, 1'b1);
    pkt = '{8'h50};
    write_pkt(1, 1'b1);
    check("wfull_sim_pre", 32'(wfull), 32'd1);
    ready_i = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      tick();
      found = valid_o && last_o;
      k++;
    end
    check("sim_found_last", 32'(found), 32'd1);
    wen = 1'b1; waddr = 4'd0; wdata = 8'h70; winc = 1'b1;
    sb.push_back({8'h70, 1'b1});
    tick();
    wen = 1'b0; winc = 1'b0;
    check("wfull_sim_post", 32'(wfull), 32'd1);
    check("drop_sim_post", 32'(drop_cnt), 32'd1);
    drain("drain_sim");

    // Maximum-length packet
    ready_i = 1'b1;
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(8'(8'hC0 ^ (i * 7)));
    write_pkt(16, 1'b1);
    drain("drain_16");

    // Reset mid-SEND with a second packet pending
    ready_i = 1'b0;
    pkt = '{8'h80, 8'h81, 8'h82, 8'h83};
    write_pkt(4, 1'b1);
    pkt = '{8'h90, 8'h91};
    write_pkt(2, 1'b1);
    wait_valid("rst_mid_valid");
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("rst_mid_wfull_pre", 32'(wfull), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_valid0", 32'(valid_o), 32'd0);
    check("rst_mid_wfull0", 32'(wfull), 32'd0);
    check("rst_mid_drop0", 32'(drop_cnt), 32'd0);
    sb.delete();
    @(posedge clk1);
    @(posedge clk1);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", 32'(valid_o), 32'd0);
    end
    ready_i = 1'b1;
    pkt = '{8'hA0, 8'hA1, 8'hA2};
    write_pkt(3, 1'b1);
    drain("drain_post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/port_packet_buffer.md
Name: port_packet_buffer

Overview:
- Per-output-port packet buffer that sits directly downstream of the packet receiver.
- It accepts byte writes (wdata/waddr/wen) into a staging slot and commits a whole packet on winc.
- It replays committed packets in arrival order on a valid/ready byte stream toward the output port.
- It drives wfull back to the receiver so the receiver can throttle.

Parameters:
- PTR_IN_SZ, 4, byte-address width; slot depth = 2**PTR_IN_SZ bytes.
- UWIDTH, 8, data byte width.
- NSLOT, 2, number of packet slots; power of two, 2..4.

Ports:
- clk1  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wdata  in  UWIDTH  byte to write.
- waddr  in  PTR_IN_SZ  byte offset within the current write slot.
- wen  in  1  byte write strobe.
- winc  in  1  one-cycle commit pulse; closes the current packet.
- wfull  out  1  no free slot available for writing.
- data_o  out  UWIDTH  output byte.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  consumer accepts data_o.
- last_o  out  1  data_o is the final byte of a packet.
- drop_cnt  out  8  count of commits rejected while full; saturates at 255.

Behaviour:
- Reset (rst low, asynchronous):
  - All slots empty; wsel=0, rsel=0.
  - wfull=0, valid_o=0, last_o=0, data_o=0, drop_cnt=0.
  - Read FSM goes to IDLE.
  - Memory contents are don't-care.
  - Reset asserted mid-packet discards all staged and committed data.
- Write side:
  - wen=1 writes wdata to mem[wsel][waddr] at the clock edge.
  - Writes while wfull=1 are ignored.
  - winc=1 with wfull=0:
    - Slot wsel is marked full.
    - len[wsel] = waddr+1 (PTR_IN_SZ+1 bits); the last byte is written in the same cycle as winc.
    - wsel advances modulo NSLOT.
  - winc=1 with wfull=1: the packet is dropped, drop_cnt increments (saturating), and wsel does not move.
  - waddr=2**PTR_IN_SZ-1 at commit gives len = 2**PTR_IN_SZ. There is no wrap within a slot.
- wfull:
  - Registered.
  - Equals 1 in the cycle after the number of full slots reaches NSLOT.
  - Clears in the cycle after a slot is released.
  - A commit and a release in the same cycle leave the occupancy unchanged.
- Read FSM states: IDLE, FETCH, SEND.
  - IDLE -> FETCH when slot rsel is full.
  - FETCH: issue read of mem[rsel][rptr] with rptr=0. Memory read latency is 1 cycle. -> SEND.
  - SEND: valid_o=1; last_o=1 when rptr==len[rsel]-1.
  - SEND, on valid_o&&ready_i and not last: rptr increments and the next byte is presented on the next cycle. data_o is prefetched so there are no bubbles in a packet.
  - SEND, on valid_o&&ready_i and last:
    - Slot rsel is released and rsel advances.
    - Next state is FETCH if the next slot is already full, else IDLE.
  - SEND with ready_i=0: data_o, last_o and valid_o are held stable.
- Latency: a commit at cycle T gives the first valid_o at T+2 when the reader is idle. There is one idle (FETCH) cycle between consecutive packets.
- The slot being read is never written: it is not wsel while full.
- Simultaneous events:
  - A commit into the last free slot in the same cycle as a final-byte handshake: wfull stays 0.
  - winc together with wen at the same waddr: the byte is written and the commit uses it.

Test Plan:
- Reset, write bytes 0x01,0x05,0x02,0xAA,0x55 at waddr 0..4 with winc on the last byte, ready_i=1:
  - valid_o rises 2 cycles after winc.
  - data_o = 01,05,02,AA,55 on consecutive cycles.
  - last_o is set only on 0x55.
- Commit 2 packets with ready_i=0:
  - wfull=1 one cycle after the second winc.
  - A third winc is dropped: drop_cnt=1 and the stored packets are unchanged.
  - Raising ready_i then returns both packets in order and wfull clears after the first last-byte handshake.
- ready_i toggled 1,0,0,1,0,1 during a 6-byte packet: each byte appears exactly once, held stable while ready_i=0, with no duplicates or skips.
- Full slots, final-byte handshake in the same cycle as a new winc: occupancy stays 2, wfull stays 1, and the new packet is the next one read.
- 16-byte packet (waddr 0..15): len=16, all bytes returned, last_o on byte index 15.
- Reset pulsed low mid-SEND on packet 1 with packet 2 pending:
  - valid_o=0 immediately (asynchronously) and wfull=0.
  - After release no stale bytes appear; a new packet reads back correctly from slot 0.
